cte: RTL and testbench

CTE -- requirements
Module: CTE

---
 rtl/cte_pkg.sv | 53 +++++
 rtl/cte_if.sv | 23 ++
 rtl/cte_yuv2rgb.sv | 24 ++
 rtl/cte.sv | 161 ++++++++++++++++
 tb/tb_cte.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cte_pkg.sv
// Shared definitions for the colour-space converter: phase encoding, fixed-point
// coefficients and clip limits.
package cte_pkg;

    typedef enum logic [1:0] {
        PH_U  = 2'd0,
        PH_Y0 = 2'd1,
        PH_V  = 2'd2,
        PH_Y1 = 2'd3
    } phase_e;

    // YUV->RGB weights are in eighths, RGB->YUV weights in sixteenths.
    localparam int RGB_FRAC = 3;
    localparam int C_YY     = 8;
    localparam int C_RV     = 13;
    localparam int C_GU     = -2;
    localparam int C_GV     = -6;
    localparam int C_BU     = 16;

    localparam int YUV_FRAC = 4;
    localparam int C_YR     = 4;
    localparam int C_YG     = 10;
    localparam int C_YB     = 2;
    localparam int C_UR     = -2;
    localparam int C_UG     = -4;
    localparam int C_UB     = 6;
    localparam int C_VR     = 6;
    localparam int C_VG     = -5;
    localparam int C_VB     = -1;

    localparam int PIX_MIN  = 0;
    localparam int PIX_MAX  = 255;
    localparam int CHR_MIN  = -128;
    localparam int CHR_MAX  = 127;

    // floor(x / 2^fracBits + 0.5), relying on the arithmetic shift for negatives
    function automatic int roundShift(input int x, input int fracBits);
        return (x + (1 <<< (fracBits - 1))) >>> fracBits;
    endfunction

    function automatic logic [7:0] clipPix(input int x);
        if (x < PIX_MIN)      return 8'd0;
        else if (x > PIX_MAX) return 8'd255;
        else                  return 8'(x);
    endfunction

    function automatic logic [7:0] clipChr(input int x);
        if (x < CHR_MIN)      return 8'h80;
        else if (x > CHR_MAX) return 8'h7F;
        else                  return 8'(x);
    endfunction

endpackage

// File: rtl/cte_if.sv
// Stream interface of the colour-space converter; the converter is the slave side.
interface cte_if;

    logic        op_mode;
    logic        in_en;
    logic [7:0]  yuv_in;
    logic [23:0] rgb_in;
    logic        busy;
    logic        out_valid;
    logic [23:0] rgb_out;
    logic [7:0]  yuv_out;

    modport master (
        output op_mode, in_en, yuv_in, rgb_in,
        input  busy, out_valid, rgb_out, yuv_out
    );

    modport slave (
        input  op_mode, in_en, yuv_in, rgb_in,
        output busy, out_valid, rgb_out, yuv_out
    );

endinterface

// File: rtl/cte_yuv2rgb.sv
// Combinational YUV->RGB pixel map with round-half-up and clipping to [0,255].
module cte_yuv2rgb
    import cte_pkg::*;
(
    input  logic [7:0]  y_i,
    input  logic [7:0]  u_i,
    input  logic [7:0]  v_i,
    output logic [23:0] rgb_o
);

    int ySig;
    int uSig;
    int vSig;

    always_comb begin
        ySig  = {24'd0, y_i};
        uSig  = {{24{u_i[7]}}, u_i};
        vSig  = {{24{v_i[7]}}, v_i};
        rgb_o = {clipPix(roundShift(C_YY * ySig + C_RV * vSig, RGB_FRAC)),
                 clipPix(roundShift(C_YY * ySig + C_GU * uSig + C_GV * vSig, RGB_FRAC)),
                 clipPix(roundShift(C_YY * ySig + C_BU * uSig, RGB_FRAC))};
    end

endmodule

// File: rtl/cte.sv
// Colour-space converter top: 4:2:2 YUV byte stream to RGB pixels, plus an
// optional RGB->YUV direction enabled by defining CTE_RGB2YUV_EN.
module cte
    import cte_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    cte_if.slave  bus
);

    phase_e      phase_q, phase_d;
    logic [7:0]  u_q, u_d;
    logic [7:0]  y0_q, y0_d;
    logic [7:0]  v_q, v_d;
    logic        valid_q, valid_d;
    logic [23:0] rgb_q, rgb_d;
    logic [7:0]  convY;
    logic [7:0]  convV;
    logic [23:0] rgbConv;
    logic        modeEff;
    logic        accept;

    // Pixel0 is formed while V arrives (Y0 from storage), pixel1 while Y1 arrives.
    assign convY = (phase_q == PH_V) ? y0_q : bus.yuv_in;
    assign convV = (phase_q == PH_V) ? bus.yuv_in : v_q;

    cte_yuv2rgb u_conv (
        .y_i   (convY),
        .u_i   (u_q),
        .v_i   (convV),
        .rgb_o (rgbConv)
    );

`ifdef CTE_RGB2YUV_EN
    logic        mode_q, mode_d;
    logic [7:0]  y1_q, y1_d;
    logic [7:0]  yuv_q, yuv_d;
    logic [7:0]  encY;
    logic [7:0]  encU;
    logic [7:0]  encV;
    int          rSig;
    int          gSig;
    int          bSig;

    always_comb begin
        rSig = {24'd0, bus.rgb_in[23:16]};
        gSig = {24'd0, bus.rgb_in[15:8]};
        bSig = {24'd0, bus.rgb_in[7:0]};
        encY = clipPix(roundShift(C_YR * rSig + C_YG * gSig + C_YB * bSig, YUV_FRAC));
        encU = clipChr(roundShift(C_UR * rSig + C_UG * gSig + C_UB * bSig, YUV_FRAC));
        encV = clipChr(roundShift(C_VR * rSig + C_VG * gSig + C_VB * bSig, YUV_FRAC));
    end

    // The mode only changes at a group boundary; mid-group the latched value rules.
    assign modeEff     = (phase_q == PH_U) ? bus.op_mode : mode_q;
    assign bus.busy    = mode_q && ((phase_q == PH_V) || (phase_q == PH_Y1));
    assign bus.yuv_out = yuv_q;
`else
    logic unusedBits;

    assign unusedBits  = ^{bus.op_mode, bus.rgb_in};
    assign modeEff     = 1'b0;
    assign bus.busy    = 1'b0;
    assign bus.yuv_out = 8'd0;
`endif

    assign accept        = bus.in_en && !bus.busy;
    assign bus.out_valid = valid_q;
    assign bus.rgb_out   = rgb_q;

    always_comb begin
        phase_d = phase_q;
        u_d     = u_q;
        y0_d    = y0_q;
        v_d     = v_q;
        valid_d = 1'b0;
        rgb_d   = rgb_q;
`ifdef CTE_RGB2YUV_EN
        mode_d  = modeEff;
        y1_d    = y1_q;
        yuv_d   = yuv_q;
`endif
        if (!modeEff) begin
            if (accept) begin
                phase_d = phase_e'(phase_q + 2'd1);
                case (phase_q)
                    PH_U:  u_d  = bus.yuv_in;
                    PH_Y0: y0_d = bus.yuv_in;
                    PH_V: begin
                        v_d     = bus.yuv_in;
                        valid_d = 1'b1;
                        rgb_d   = rgbConv;
                    end
                    PH_Y1: begin
                        valid_d = 1'b1;
                        rgb_d   = rgbConv;
                    end
                endcase
            end
        end
`ifdef CTE_RGB2YUV_EN
        // Two pixels in, then two busy cycles drain the remaining V and Y1 bytes.
        else begin
            case (phase_q)
                PH_U: if (accept) begin
                    yuv_d   = encU;
                    y0_d    = encY;
                    v_d     = encV;
                    valid_d = 1'b1;
                    phase_d = PH_Y0;
                end
                PH_Y0: if (accept) begin
                    yuv_d   = y0_q;
                    y1_d    = encY;
                    valid_d = 1'b1;
                    phase_d = PH_V;
                end
                PH_V: begin
                    yuv_d   = v_q;
                    valid_d = 1'b1;
                    phase_d = PH_Y1;
                end
                PH_Y1: begin
                    yuv_d   = y1_q;
                    valid_d = 1'b1;
                    phase_d = PH_U;
                end
            endcase
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_U;
            u_q     <= 8'd0;
            y0_q    <= 8'd0;
            v_q     <= 8'd0;
            valid_q <= 1'b0;
            rgb_q   <= 24'd0;
`ifdef CTE_RGB2YUV_EN
            mode_q  <= 1'b0;
            y1_q    <= 8'd0;
            yuv_q   <= 8'd0;
`endif
        end else begin
            phase_q <= phase_d;
            u_q     <= u_d;
            y0_q    <= y0_d;
            v_q     <= v_d;
            valid_q <= valid_d;
            rgb_q   <= rgb_d;
`ifdef CTE_RGB2YUV_EN
            mode_q  <= mode_d;
            y1_q    <= y1_d;
            yuv_q   <= yuv_d;
`endif
        end
    end

endmodule

// File: tb/tb_cte.sv
// Self-checking bench for cte: known vectors, random stream against a real-valued
// reference model, partial groups, mode changes and reset behaviour.
module tb_cte;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    cte_if bus ();

    cte dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  grp [4];
    int          pos = 0;
    logic [23:0] lastRgb = 24'd0;

    function automatic logic [7:0] roundClip(input real x, input int lo, input int hi);
        int k;
        k = int'($floor(x + 0.5));
        if (k < lo) k = lo;
        if (k > hi) k = hi;
        return 8'(k);
    endfunction

    function automatic int sgn(input logic [7:0] b);
        return int'($signed(b));
    endfunction

    function automatic logic [23:0] refRgb(input int y, input int u, input int v);
        return {roundClip(y + 1.625 * v, 0, 255),
                roundClip(y - 0.25 * u - 0.75 * v, 0, 255),
                roundClip(y + 2.0 * u, 0, 255)};
    endfunction

    // Reference for one accepted YUV byte: group position decides whether a pixel emerges.
    task automatic modelAccept(input logic [7:0] b, output bit expValid);
        grp[pos] = b;
        expValid = 1'b0;
        if (pos == 2) begin
            lastRgb  = refRgb(int'(grp[1]), sgn(grp[0]), sgn(grp[2]));
            expValid = 1'b1;
        end else if (pos == 3) begin
            lastRgb  = refRgb(int'(grp[3]), sgn(grp[0]), sgn(grp[2]));
            expValid = 1'b1;
        end
        pos = (pos + 1) % 4;
    endtask

    task automatic driveCycle(input logic en, input logic [7:0] b, input logic mode);
        bus.in_en   = en;
        bus.yuv_in  = b;
        bus.op_mode = mode;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.busy, bus.rgb_out, bus.yuv_out} !== 34'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want 0",
                     {bus.out_valid, bus.busy, bus.rgb_out, bus.yuv_out});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        driveCycle(1'b0, 8'hA5, 1'b0);
        checks++;
        if ({bus.out_valid, bus.rgb_out} !== 25'd0) begin
            errors++;
            $display("[TB] FAIL reset_idle got %h want 0", {bus.out_valid, bus.rgb_out});
        end
    endtask

    task automatic test_known_vectors();
        logic [31:0] vecB [5];
        logic [23:0] vecE [5];
        logic [7:0]  b;
        bit          expV;
        vecB = '{32'h00800080, 32'h10640064, 32'h000A010A, 32'h40F000F0, 32'h80100010};
        vecE = '{24'h808080, 24'h646084, 24'h0C090A, 24'hF0E0FF, 24'h103000};
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = vecB[i][31 - 8 * k -: 8];
                driveCycle(1'b1, b, 1'b0);
                modelAccept(b, expV);
                if (expV) lastRgb = vecE[i];
                checks++;
                if (bus.out_valid !== (k >= 2)) begin
                    errors++;
                    $display("[TB] FAIL vec%0d_b%0d_valid got %b want %b", i, k, bus.out_valid, k >= 2);
                end
                checks++;
                if (bus.rgb_out !== lastRgb) begin
                    errors++;
                    $display("[TB] FAIL vec%0d_b%0d_rgb got %h want %h", i, k, bus.rgb_out, lastRgb);
                end
            end
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] b;
        bit         expV;
        int         pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            b = 8'($urandom);
            driveCycle(1'b1, b, 1'b0);
            modelAccept(b, expV);
            if (bus.out_valid === 1'b1) pulses++;
            checks++;
            if ((bus.out_valid !== expV) || (bus.rgb_out !== lastRgb) || (bus.busy !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL stream_%0d got v=%b rgb=%h busy=%b want v=%b rgb=%h busy=0",
                         i, bus.out_valid, bus.rgb_out, bus.busy, expV, lastRgb);
            end
        end
        checks++;
        if (pulses != 500) begin
            errors++;
            $display("[TB] FAIL stream_pulses got %0d want 500", pulses);
        end
    endtask

    task automatic test_partial_group();
        logic [7:0] b;
        bit         expV;
        for (int i = 0; i < 12; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                driveCycle(1'b0, 8'($urandom), 1'b0);
                checks++;
                if ((bus.out_valid !== 1'b0) || (bus.rgb_out !== lastRgb)) begin
                    errors++;
                    $display("[TB] FAIL gap_%0d got v=%b rgb=%h want v=0 rgb=%h",
                             i, bus.out_valid, bus.rgb_out, lastRgb);
                end
            end
            b = 8'($urandom);
            driveCycle(1'b1, b, 1'b0);
            modelAccept(b, expV);
            checks++;
            if ((bus.out_valid !== expV) || (bus.rgb_out !== lastRgb)) begin
                errors++;
                $display("[TB] FAIL partial_%0d got v=%b rgb=%h want v=%b rgb=%h",
                         i, bus.out_valid, bus.rgb_out, expV, lastRgb);
            end
        end
    endtask

    task automatic test_mode_change();
        logic [7:0] b;
        logic       m;
        bit         expV;
        for (int i = 0; i < 32; i++) begin
            b = 8'($urandom);
            m = (pos == 0) ? 1'b0 : 1'($urandom);
            driveCycle(1'b1, b, m);
            modelAccept(b, expV);
            checks++;
            if ((bus.out_valid !== expV) || (bus.rgb_out !== lastRgb) || (bus.busy !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL modechg_%0d got v=%b rgb=%h busy=%b want v=%b rgb=%h busy=0",
                         i, bus.out_valid, bus.rgb_out, bus.busy, expV, lastRgb);
            end
        end
        bus.op_mode = 1'b0;
    endtask

    task automatic test_reset_midgroup();
        logic [31:0] seq;
        logic [7:0]  b;
        bit          expV;
        driveCycle(1'b1, 8'h00, 1'b0);
        driveCycle(1'b1, 8'h80, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_pre_valid got %b want 0", bus.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.rgb_out} !== 25'd0) begin
            errors++;
            $display("[TB] FAIL midrst_clear got %h want 0", {bus.out_valid, bus.rgb_out});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        pos     = 0;
        lastRgb = 24'd0;
        seq     = 32'h00800080;
        for (int k = 0; k < 4; k++) begin
            b = seq[31 - 8 * k -: 8];
            driveCycle(1'b1, b, 1'b0);
            modelAccept(b, expV);
            checks++;
            if ((bus.out_valid !== (k >= 2)) || (bus.rgb_out !== ((k >= 2) ? 24'h808080 : 24'd0))) begin
                errors++;
                $display("[TB] FAIL midrst_b%0d got v=%b rgb=%h want v=%b rgb=%h", k,
                         bus.out_valid, bus.rgb_out, k >= 2, (k >= 2) ? 24'h808080 : 24'd0);
            end
        end
    endtask

`ifdef CTE_RGB2YUV_EN
    task automatic test_rgb2yuv();
        logic [23:0] px [2];
        logic [7:0]  expB [4];
        bit          expBusy [4];
        int          r;
        int          g;
        int          b;
        expBusy = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int n = 0; n < 6; n++) begin
            px[0] = 24'($urandom);
            px[1] = 24'($urandom);
            r = int'(px[0][23:16]); g = int'(px[0][15:8]); b = int'(px[0][7:0]);
            expB[0] = roundClip(-0.125 * r - 0.25 * g + 0.375 * b, -128, 127);
            expB[1] = roundClip(0.25 * r + 0.625 * g + 0.125 * b, 0, 255);
            expB[2] = roundClip(0.375 * r - 0.3125 * g - 0.0625 * b, -128, 127);
            r = int'(px[1][23:16]); g = int'(px[1][15:8]); b = int'(px[1][7:0]);
            expB[3] = roundClip(0.25 * r + 0.625 * g + 0.125 * b, 0, 255);
            for (int k = 0; k < 4; k++) begin
                bus.rgb_in = (k < 2) ? px[k] : 24'($urandom);
                driveCycle(1'b1, 8'($urandom), (k == 0) ? 1'b1 : 1'($urandom));
                checks++;
                if ((bus.out_valid !== 1'b1) || (bus.yuv_out !== expB[k]) ||
                    (bus.busy !== expBusy[k]) || (bus.rgb_out !== lastRgb)) begin
                    errors++;
                    $display("[TB] FAIL enc%0d_b%0d got v=%b yuv=%h busy=%b rgb=%h want v=1 yuv=%h busy=%b rgb=%h",
                             n, k, bus.out_valid, bus.yuv_out, bus.busy, bus.rgb_out,
                             expB[k], expBusy[k], lastRgb);
                end
            end
        end
        bus.op_mode = 1'b0;
    endtask
`endif

    initial begin
        bus.op_mode = 1'b0;
        bus.in_en   = 1'b0;
        bus.yuv_in  = 8'd0;
        bus.rgb_in  = 24'd0;
        test_reset();
        test_known_vectors();
        test_random_stream();
        test_partial_group();
        test_mode_change();
`ifdef CTE_RGB2YUV_EN
        test_rgb2yuv();
`endif
        test_reset_midgroup();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
